cpu_step_controller: RTL and testbench

//   Sequencer for the single-cycle CPU datapath: generates the one-cycle CPU step

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/cpu_step_controller_settle_timer.sv | 43 ++++
 rtl/cpu_step_controller.sv | 165 ++++++++++++++++
 tb/tb_cpu_step_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg : shared state encoding and defaults for the CPU step sequencer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [5:0] c_halt_op_default = 6'h3F;

endpackage

`default_nettype wire

// File: rtl/cpu_step_controller_settle_timer.sv
// ============================================================================
// settle_timer : loads SETTLE-1 on a step and flags the final settle cycle
// Revision     : 1.0
// ============================================================================
`default_nettype none

module settle_timer #(
   parameter int SETTLE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic last_o
);

   localparam int             c_w    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [c_w-1:0] c_load = c_w'(SETTLE - 1);

   logic [c_w-1:0] cnt_q;
   logic [c_w-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = c_load;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - c_w'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/cpu_step_controller.sv
// ============================================================================
// cpu_step_controller : issues one-cycle CPU step enables with a settle gap
// Revision            : 1.0
// ============================================================================
`default_nettype none

module cpu_step_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int         SETTLE  = 4,
   parameter int         CNT_W   = 16,
   parameter logic [5:0] HALT_OP = c_halt_op_default
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             key_pulse,
   input  logic             mode_run,
   input  logic [CNT_W-1:0] run_count,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   input  logic [31:0]      ins,
   output logic             step_pulse,
   output logic             busy,
   output logic             running,
   output logic             halted,
   output logic             bp_hit,
   output logic             done,
   output logic [CNT_W-1:0] step_cnt
);

   state_t           state_q,   state_d;
   logic             mode_q,    mode_d;
   logic             bounded_q, bounded_d;
   logic [CNT_W-1:0] remain_q,  remain_d;
   logic             abort_q,   abort_d;
   logic             bp_hit_q,  bp_hit_d;
   logic             done_q,    done_d;
   logic             running_q, running_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic w_last;
   logic w_halt_ins;
   logic w_abort;
   logic w_finish;
   logic w_unused_ins;

   assign w_halt_ins   = (ins[31:26] == HALT_OP);
   // A key press on the final settle cycle of a run still counts as an abort.
   assign w_abort      = abort_q | (key_pulse & mode_q);
   assign w_unused_ins = ^ins[25:0];

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk    (clk),
      .rst    (RST),
      .load_i (state_q == ST_STEP),
      .last_o (w_last)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      bounded_d = bounded_q;
      remain_d  = remain_q;
      abort_d   = abort_q;
      bp_hit_d  = bp_hit_q;
      running_d = running_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      w_finish  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (key_pulse) begin
               if (w_halt_ins) begin
                  state_d = ST_HALTED;
               end else begin
                  mode_d    = mode_run;
                  remain_d  = run_count;
                  bounded_d = (run_count != '0);
                  bp_hit_d  = 1'b0;
                  abort_d   = 1'b0;
                  running_d = mode_run;
                  state_d   = ST_STEP;
               end
            end
         end
         ST_STEP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bounded_q) begin
               remain_d = remain_q - CNT_W'(1);
            end
            abort_d = w_abort;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            abort_d = w_abort;
            if (w_last) begin
               w_finish = 1'b1;
               if (w_halt_ins) begin
                  state_d = ST_HALTED;
               end else if (w_abort || !mode_q) begin
                  state_d = ST_IDLE;
               end else if (bp_en && (pc == bp_addr)) begin
                  bp_hit_d = 1'b1;
                  state_d  = ST_IDLE;
               end else if (bounded_q && (remain_q == '0)) begin
                  state_d = ST_IDLE;
               end else begin
                  w_finish = 1'b0;
                  state_d  = ST_STEP;
               end
            end
            if (w_finish) begin
               done_d    = 1'b1;
               running_d = 1'b0;
               abort_d   = 1'b0;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         mode_q    <= 1'b0;
         bounded_q <= 1'b0;
         remain_q  <= '0;
         abort_q   <= 1'b0;
         bp_hit_q  <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         bounded_q <= bounded_d;
         remain_q  <= remain_d;
         abort_q   <= abort_d;
         bp_hit_q  <= bp_hit_d;
         done_q    <= done_d;
         running_q <= running_d;
         cnt_q     <= cnt_d;
      end
   end

   assign step_pulse = (state_q == ST_STEP);
   assign busy       = (state_q == ST_STEP) || (state_q == ST_SETTLE);
   assign halted     = (state_q == ST_HALTED);
   assign running    = running_q;
   assign bp_hit     = bp_hit_q;
   assign done       = done_q;
   assign step_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
// ============================================================================
// tb_cpu_step_controller : directed and randomized bench for the step sequencer
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_step_controller;

   localparam int SETTLE = 4;
   localparam int CNT_W  = 16;

   logic             clk       = 1'b0;
   logic             RST       = 1'b1;
   logic             key_pulse = 1'b0;
   logic             mode_run  = 1'b0;
   logic [CNT_W-1:0] run_count = '0;
   logic             bp_en     = 1'b0;
   logic [31:0]      bp_addr   = '0;
   logic [31:0]      pc;
   logic [31:0]      ins;
   logic             step_pulse, busy, running, halted, bp_hit, done;
   logic [CNT_W-1:0] step_cnt;

   // Bench CPU: PC advances by 4 for every step the reference expects.
   logic [31:0] pc_base = '0;
   logic [31:0] mp0     = '0;
   logic [31:0] mpulses = '0;
   logic [31:0] halt_pc = '0;
   logic        halt_en = 1'b0;

   assign pc  = pc_base + ((mpulses - mp0) << 2);
   assign ins = (halt_en && (pc == halt_pc)) ? {6'h3F, 26'h0} : {6'h08, pc[25:0]};

   always #5 clk = ~clk;

   cpu_step_controller #(
      .SETTLE  (SETTLE),
      .CNT_W   (CNT_W),
      .HALT_OP (6'h3F)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .key_pulse  (key_pulse),
      .mode_run   (mode_run),
      .run_count  (run_count),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .ins        (ins),
      .step_pulse (step_pulse),
      .busy       (busy),
      .running    (running),
      .halted     (halted),
      .bp_hit     (bp_hit),
      .done       (done),
      .step_cnt   (step_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference: m_t is the cycle offset inside the current step window (0 = pulse).
   bit               m_active, m_halted, m_run, m_bounded, m_abort, m_bph, m_done;
   int               m_t, m_left;
   logic [CNT_W-1:0] m_cnt;

   int n_pulse, n_busy, n_done, cyc, first_p, last_p;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_halted = 1'b0; m_run = 1'b0; m_bounded = 1'b0;
      m_abort = 1'b0;  m_bph = 1'b0;    m_done = 1'b0;
      m_t = 0; m_left = 0; m_cnt = '0;
   endtask

   task automatic model_step();
      bit halt_op;
      halt_op = (ins[31:26] == 6'h3F);
      if (RST) begin
         model_reset();
      end else begin
         m_done = 1'b0;
         if (m_halted) begin
            m_halted = 1'b1;
         end else if (!m_active) begin
            if (key_pulse) begin
               if (halt_op) begin
                  m_halted = 1'b1;
               end else begin
                  m_active = 1'b1; m_t = 0; m_run = mode_run;
                  m_left = int'(run_count); m_bounded = (run_count != 0);
                  m_bph = 1'b0; m_abort = 1'b0;
               end
            end
         end else begin
            if (key_pulse && m_run) m_abort = 1'b1;
            if (m_t == 0) begin
               m_cnt = m_cnt + 1'b1;
               mpulses = mpulses + 1;
               if (m_bounded) m_left = m_left - 1;
            end
            if (m_t == SETTLE) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               if (halt_op) m_halted = 1'b1;
               else if (m_abort || !m_run) m_active = 1'b0;
               else if (bp_en && (pc == bp_addr)) m_bph = 1'b1;
               else if (m_bounded && (m_left == 0)) m_active = 1'b0;
               else begin
                  m_active = 1'b1;
                  m_done   = 1'b0;
                  m_t      = 0;
               end
               if (!m_active) m_abort = 1'b0;
            end else begin
               m_t = m_t + 1;
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      chk("step_pulse", 32'(step_pulse), 32'(m_active && (m_t == 0)));
      chk("busy",       32'(busy),       32'(m_active));
      chk("running",    32'(running),    32'(m_active && m_run));
      chk("halted",     32'(halted),     32'(m_halted));
      chk("bp_hit",     32'(bp_hit),     32'(m_bph));
      chk("done",       32'(done),       32'(m_done));
      chk("step_cnt",   32'(step_cnt),   32'(m_cnt));
      cyc++;
      if (step_pulse) begin
         n_pulse++;
         if (first_p < 0) first_p = cyc;
         last_p = cyc;
      end
      if (busy) n_busy++;
      if (done) n_done++;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic press();
      key_pulse = 1'b1;
      cycle();
      key_pulse = 1'b0;
   endtask

   task automatic clr();
      n_pulse = 0; n_busy = 0; n_done = 0; cyc = 0; first_p = -1; last_p = -1;
   endtask

   task automatic rebase(input logic [31:0] b);
      pc_base = b;
      mp0     = mpulses;
   endtask

   // Called just after an active edge; asserts reset between edges.
   task automatic async_reset();
      #2;
      RST = 1'b1;
      #1;
      chk("rst_step_pulse", 32'(step_pulse), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_running",    32'(running),    32'd0);
      chk("rst_halted",     32'(halted),     32'd0);
      chk("rst_bp_hit",     32'(bp_hit),     32'd0);
      chk("rst_done",       32'(done),       32'd0);
      chk("rst_step_cnt",   32'(step_cnt),   32'd0);
      model_reset();
      run(2);
      #3;
      RST = 1'b0;
   endtask

   initial begin
      model_reset();
      clr();
      @(posedge clk);
      #1;
      run(3);
      RST = 1'b0;
      run(2);

      // Single step
      mode_run = 1'b0;
      clr(); press(); run(8);
      chk("t1_pulses",      32'(n_pulse), 32'd1);
      chk("t1_busy_cycles", 32'(n_busy),  32'd5);
      chk("t1_done_cycles", 32'(n_done),  32'd1);
      chk("t1_latency",     32'(first_p), 32'd2);
      chk("t1_step_cnt",    32'(step_cnt), 32'd1);

      // Bounded run of 5
      mode_run = 1'b1; run_count = 16'd5;
      clr(); press(); run(40);
      chk("t2_pulses",   32'(n_pulse), 32'd5);
      chk("t2_span",     32'(last_p - first_p), 32'd20);
      chk("t2_step_cnt", 32'(step_cnt), 32'd6);
      chk("t2_running",  32'(running), 32'd0);
      chk("t2_done",     32'(n_done), 32'd1);

      // Breakpoint at 0x0C, then resume past it
      rebase(32'h0); bp_en = 1'b1; bp_addr = 32'h0000_000C; run_count = '0;
      clr(); press(); run(30);
      chk("t3_pulses",   32'(n_pulse), 32'd3);
      chk("t3_bp_hit",   32'(bp_hit), 32'd1);
      chk("t3_step_cnt", 32'(step_cnt), 32'd9);
      run_count = 16'd2;
      clr(); press();
      chk("t3_bp_clear", 32'(bp_hit), 32'd0);
      run(20);
      chk("t3_resume_pulses", 32'(n_pulse), 32'd2);
      chk("t3_resume_cnt",    32'(step_cnt), 32'd11);

      // Abort by key mid-settle of an unbounded run
      bp_en = 1'b0; run_count = '0;
      clr(); press(); run(8); press(); run(12);
      chk("t5_pulses",  32'(n_pulse), 32'd2);
      chk("t5_done",    32'(n_done), 32'd1);
      chk("t5_busy",    32'(busy), 32'd0);
      chk("t5_step_cnt", 32'(step_cnt), 32'd13);

      // Halt instruction after the 2nd pulse
      rebase(32'h0); halt_pc = 32'h8; halt_en = 1'b1;
      clr(); press(); run(20);
      chk("t4_pulses",   32'(n_pulse), 32'd2);
      chk("t4_halted",   32'(halted), 32'd1);
      chk("t4_step_cnt", 32'(step_cnt), 32'd15);
      clr();
      repeat (3) begin
         press(); run(3);
      end
      chk("t4_locked_pulses", 32'(n_pulse), 32'd0);
      chk("t4_still_halted",  32'(halted), 32'd1);

      // Reset out of HALTED, then reset mid-settle, then a clean restart
      async_reset();
      halt_en = 1'b0; rebase(32'h0); run_count = '0; mode_run = 1'b1;
      press(); run(2);
      async_reset();
      mode_run = 1'b0;
      clr(); press(); run(8);
      chk("t6_pulses",   32'(n_pulse), 32'd1);
      chk("t6_step_cnt", 32'(step_cnt), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (m_halted && ($urandom_range(0, 15) == 0)) begin
            async_reset();
            halt_en = 1'b0;
         end
         if (!m_active && !m_halted && ($urandom_range(0, 3) == 0)) begin
            mode_run  = ($urandom_range(0, 3) != 0);
            run_count = CNT_W'($urandom_range(0, 4));
            bp_en     = 1'($urandom_range(0, 1));
            bp_addr   = pc + (32'($urandom_range(0, 4)) << 2);
            halt_en   = ($urandom_range(0, 7) == 0);
            halt_pc   = pc + (32'($urandom_range(0, 5)) << 2);
         end
         if ($urandom_range(0, 11) == 0) press();
         else cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
